// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Types and constants shared across the RV32 core pipeline.
//   XLEN / ILEN       : data and instruction widths
//   DEFAULT_RESET_PC  : PC loaded at reset unless a stage overrides it
//   fetch_entry_t     : {pc, inst} pair handed from fetch to decode
//   pc_plus4()        : sequential next-PC helper, wraps modulo 2^XLEN
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Small synchronous FIFO of fetch_entry_t between the PC logic and decode.
// A push while full is accepted when a pop happens on the same edge, so the
// buffer streams at one entry per cycle even at full occupancy. Flush has
// priority over push and pop.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_flush           : empty the buffer (pointers and count to zero)
//   i_push, i_data    : write i_data at the tail
//   i_pop             : advance the head
//   o_head            : entry at the head (undefined content when empty)
//   o_count           : number of valid entries
//   o_full, o_empty   : occupancy flags
// -----------------------------------------------------------------------------
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_pop,
  input  fetch_entry_t      i_data,
  output fetch_entry_t      o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Guard against overflow/underflow; a push at full is legal only alongside a pop.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage array; entries are cleared on reset so no X ever reaches the head.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// RV32 instruction-fetch stage. Owns the fetch PC, reads a combinational
// instruction memory with zero latency, buffers {pc, inst} pairs and presents
// them to decode over valid/ready. A redirect flushes the buffer and reloads
// the PC; it wins over any push or pop in the same cycle.
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   defined   : adds o_misaligned; a misaligned redirect target is loaded as-is
//               and suspends fetch until an aligned redirect arrives.
//   undefined : redirect target bits [1:0] are forced to zero.
// Ports:
//   i_clk, i_rst                : clock, asynchronous active-high reset
//   o_imem_pc / i_imem_inst     : instruction memory address / returned word
//   i_redirect, i_redirect_pc   : control-flow redirect and its target
//   o_valid, i_ready            : handshake to decode
//   o_inst, o_pc, o_pc_plus4    : head entry (all zero while empty)
//   o_misaligned                : misaligned-target flag (macro builds only)
// -----------------------------------------------------------------------------
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [XLEN-1:0] o_imem_pc,
  input  logic [ILEN-1:0] i_imem_inst,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            o_misaligned,
`endif
  output logic            o_valid,
  input  logic            i_ready,
  output logic [ILEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_target_pc;
  logic            w_suspend;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic [CNT_W-1:0] w_unused_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_new_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misaligned;

  assign w_target_pc  = i_redirect_pc;
  assign w_suspend    = r_misaligned;
  assign o_misaligned = r_misaligned;

  // Misaligned flag: set or cleared only by a redirect, by its target alignment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_misaligned <= 1'b0;
    end else if (i_redirect) begin
      r_misaligned <= |i_redirect_pc[1:0];
    end else begin
      r_misaligned <= r_misaligned;
    end
  end
`else
  logic [1:0] w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = i_redirect_pc[1:0];
  assign w_target_pc      = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign w_suspend        = 1'b0;
`endif

  assign o_valid   = ~w_empty;
  assign o_imem_pc = r_pc;

  // A pop frees a slot on the same edge, which lets a full buffer keep streaming.
  assign w_pop  = o_valid & i_ready;
  assign w_push = ~i_redirect & ~w_suspend & (~w_full | w_pop);

  assign w_new_entry.pc   = r_pc;
  assign w_new_entry.inst = i_imem_inst;

  // Fetch PC: redirect > sequential advance on push > hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= w_target_pc;
    end else if (w_push) begin
      r_pc <= pc_plus4(r_pc);
    end else begin
      r_pc <= r_pc;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_new_entry),
    .o_head  (w_head),
    .o_count (w_unused_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head outputs read zero while the buffer is empty.
  always_comb begin
    o_pc       = {XLEN{1'b0}};
    o_inst     = {ILEN{1'b0}};
    o_pc_plus4 = {XLEN{1'b0}};
    if (o_valid) begin
      o_pc       = w_head.pc;
      o_inst     = w_head.inst;
      o_pc_plus4 = pc_plus4(w_head.pc);
    end else begin
      o_pc       = {XLEN{1'b0}};
      o_inst     = {ILEN{1'b0}};
      o_pc_plus4 = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed vector table for the fetch scenarios, an asynchronous mid-run
// reset, then random ready/redirect traffic against a queue-based model.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: fixed words at 0/4/8, address hash elsewhere.
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    logic [31:0] r;
    if (a == 32'h0)      r = 32'h0000_0013;
    else if (a == 32'h4) r = 32'h0010_0093;
    else if (a == 32'h8) r = 32'h0020_0113;
    else                 r = a ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
    return r;
  endfunction

  assign imem_inst = imem_f(imem_pc);

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_pc     (imem_pc),
    .i_imem_inst   (imem_inst),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .o_misaligned  (misaligned),
`endif
    .o_valid       (valid),
    .i_ready       (ready),
    .o_inst        (inst),
    .o_pc          (pc),
    .o_pc_plus4    (pc_plus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    #12;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_before;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_plus4;
    logic [31:0] exp_imem;
    logic        exp_mis;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic rb, input logic rd, input logic rx,
                              input logic [31:0] rpc, input logic v,
                              input logic [31:0] p, input logic [31:0] p4,
                              input logic [31:0] im, input logic mis);
    vec_t t;
    t.rst_before = rb; t.ready = rd; t.redir = rx; t.rpc = rpc;
    t.exp_valid = v;
    t.exp_pc    = v ? p : 32'h0;
    t.exp_inst  = v ? imem_f(p) : 32'h0;
    t.exp_plus4 = v ? p4 : 32'h0;
    t.exp_imem  = im;
    t.exp_mis   = mis;
    return t;
  endfunction

  // ---------------- reference model ----------------
  fetch_entry_t mq[$];
  logic [31:0]  m_pc;
  logic         m_mis;

  task automatic model_reset();
    mq.delete();
    m_pc  = 32'h0;
    m_mis = 1'b0;
  endtask

  // One clock edge of fetch behaviour, from the current (pre-edge) inputs.
  task automatic model_step();
    int sz;
    logic pop;
    fetch_entry_t e;
    sz  = mq.size();
    pop = (sz > 0) && ready;
    if (redirect) begin
      mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc  = redirect_pc;
      m_mis = (redirect_pc % 4) != 0;
`else
      m_pc  = redirect_pc - (redirect_pc % 4);
`endif
    end else begin
      if (pop) e = mq.pop_front();
      if (!m_mis && (sz < DEPTH || pop)) begin
        e.pc   = m_pc;
        e.inst = imem_f(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic model_check(input int cyc);
    logic [31:0] ep;
    logic [31:0] ei;
    ep = (mq.size() > 0) ? mq[0].pc : 32'h0;
    ei = (mq.size() > 0) ? mq[0].inst : 32'h0;
    chk($sformatf("rnd%0d valid", cyc), {31'h0, valid}, {31'h0, mq.size() > 0});
    chk($sformatf("rnd%0d pc", cyc), pc, ep);
    chk($sformatf("rnd%0d inst", cyc), inst, ei);
    chk($sformatf("rnd%0d pc_plus4", cyc), pc_plus4, (mq.size() > 0) ? ep + 32'd4 : 32'h0);
    chk($sformatf("rnd%0d imem_pc", cyc), imem_pc, m_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk($sformatf("rnd%0d misaligned", cyc), {31'h0, misaligned}, {31'h0, m_mis});
`endif
  endtask

  logic m_mis_exp;
  logic [31:0] tmp;

  initial begin
    logic [31:0] im16, im17;
    logic v17;
`ifdef FETCH_MISALIGN_TRAP_EN
    im16 = 32'h102; im17 = 32'h102; v17 = 1'b0; m_mis_exp = 1'b1;
`else
    im16 = 32'h100; im17 = 32'h104; v17 = 1'b1; m_mis_exp = 1'b0;
`endif
    // Ready held high from reset: 0x0, 0x4, 0x8 back to back.
    tbl[0]  = mk(1, 1, 0, 32'h0, 1, 32'h0, 32'h4, 32'h4, 0);
    tbl[1]  = mk(0, 1, 0, 32'h0, 1, 32'h4, 32'h8, 32'h8, 0);
    tbl[2]  = mk(0, 1, 0, 32'h0, 1, 32'h8, 32'hC, 32'hC, 0);
    // Stall from reset: two entries buffered, PC holds at 0x8.
    tbl[3]  = mk(1, 0, 0, 32'h0, 1, 32'h0, 32'h4, 32'h4, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0, 1, 32'h0, 32'h4, 32'h8, 0);
    tbl[5]  = mk(0, 0, 0, 32'h0, 1, 32'h0, 32'h4, 32'h8, 0);
    tbl[6]  = mk(0, 0, 0, 32'h0, 1, 32'h0, 32'h4, 32'h8, 0);
    tbl[7]  = mk(0, 0, 0, 32'h0, 1, 32'h0, 32'h4, 32'h8, 0);
    // Release while full: pop and push on one edge, PC advances.
    tbl[8]  = mk(0, 1, 0, 32'h0, 1, 32'h4, 32'h8, 32'hC, 0);
    tbl[9]  = mk(0, 1, 0, 32'h0, 1, 32'h8, 32'hC, 32'h10, 0);
    tbl[10] = mk(0, 0, 0, 32'h0, 1, 32'h8, 32'hC, 32'h10, 0);
    // Redirect with a full buffer.
    tbl[11] = mk(0, 1, 1, 32'h100, 0, 32'h0, 32'h0, 32'h100, 0);
    tbl[12] = mk(0, 1, 0, 32'h0, 1, 32'h100, 32'h104, 32'h104, 0);
    // PC wrap at the top of the address space.
    tbl[13] = mk(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0);
    tbl[14] = mk(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
    tbl[15] = mk(0, 1, 0, 32'h0, 1, 32'h0, 32'h4, 32'h4, 0);
    // Misaligned redirect, then an aligned one.
    tbl[16] = mk(0, 1, 1, 32'h102, 0, 32'h0, 32'h0, im16, m_mis_exp);
    tbl[17] = mk(0, 1, 0, 32'h0, v17, 32'h100, 32'h104, im17, m_mis_exp);
    tbl[18] = mk(0, 1, 1, 32'h200, 0, 32'h0, 32'h0, 32'h200, 0);
    tbl[19] = mk(0, 1, 0, 32'h0, 1, 32'h200, 32'h204, 32'h204, 0);

    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #3;
    chk("reset valid", {31'h0, valid}, 32'h0);
    chk("reset imem_pc", imem_pc, 32'h0);
    chk("reset pc", pc, 32'h0);
    chk("reset inst", inst, 32'h0);
    chk("reset pc_plus4", pc_plus4, 32'h0);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst_before) do_reset();
      ready       = tbl[i].ready;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      chk($sformatf("vec%0d valid", i), {31'h0, valid}, {31'h0, tbl[i].exp_valid});
      chk($sformatf("vec%0d pc", i), pc, tbl[i].exp_pc);
      chk($sformatf("vec%0d inst", i), inst, tbl[i].exp_inst);
      chk($sformatf("vec%0d pc_plus4", i), pc_plus4, tbl[i].exp_plus4);
      chk($sformatf("vec%0d imem_pc", i), imem_pc, tbl[i].exp_imem);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk($sformatf("vec%0d misaligned", i), {31'h0, misaligned}, {31'h0, tbl[i].exp_mis});
`endif
    end

    // Asynchronous reset in the middle of a cycle, no clock edge needed.
    ready = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst valid", {31'h0, valid}, 32'h0);
    chk("midrst imem_pc", imem_pc, 32'h0);
    chk("midrst pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      ready    = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 19) == 0);
      tmp = $urandom();
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFF8;
        1:       redirect_pc = tmp;
        default: redirect_pc = {tmp[31:2], 2'b00};
      endcase
      model_step();
      @(posedge clk);
      #1;
      model_check(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
